// File: rtl/sobel_pkg.sv
// rtl/sobel_pkg.sv - shared image geometry defaults, coordinate width and source FSM states
package sobel_pkg;

  localparam int IMG_WIDTH_DEF  = 960;
  localparam int IMG_HEIGHT_DEF = 540;
  localparam int COORD_W        = 10;

  // Raster source states; the blank state is only reachable when line blanking is compiled in
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_HBLANK = 2'd2,
    ST_DRAIN  = 2'd3
  } src_state_t;

endpackage

// File: rtl/raster_counter.sv
// rtl/raster_counter.sv - x/y/linear-address raster counters with line-end and frame-end flags
module raster_counter
  import sobel_pkg::*;
#(
  parameter int IMG_WIDTH  = IMG_WIDTH_DEF,
  parameter int IMG_HEIGHT = IMG_HEIGHT_DEF,
  parameter int ADDR_W     = 20
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               en,
  output logic [COORD_W-1:0] x_cnt,
  output logic [COORD_W-1:0] y_cnt,
  output logic [ADDR_W-1:0]  addr,
  output logic               line_end,
  output logic               frame_end
);

  localparam logic [COORD_W-1:0] X_LAST = COORD_W'(IMG_WIDTH - 1);
  localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(IMG_HEIGHT - 1);

  assign line_end  = (x_cnt == X_LAST);
  assign frame_end = line_end && (y_cnt == Y_LAST);

  // Advance one pixel per enabled cycle; the last pixel of the frame wraps everything to zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_cnt <= '0;
      y_cnt <= '0;
      addr  <= '0;
    end else if (clr || (en && frame_end)) begin
      x_cnt <= '0;
      y_cnt <= '0;
      addr  <= '0;
    end else if (en) begin
      addr <= addr + 1'b1;
      if (line_end) begin
        x_cnt <= '0;
        y_cnt <= y_cnt + 1'b1;
      end else begin
        x_cnt <= x_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/frame_stream_source.sv
// rtl/frame_stream_source.sv - raster-scan pixel source for the Sobel stage; FRAME_SRC_HBLANK_EN adds inter-line blanking
module frame_stream_source
  import sobel_pkg::*;
#(
  parameter int IMG_WIDTH  = IMG_WIDTH_DEF,
  parameter int IMG_HEIGHT = IMG_HEIGHT_DEF,
  parameter int ADDR_W     = 20,
  parameter int HBLANK     = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               hold,
  output logic               mem_rd_en,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic [7:0]         mem_rd_data,
  output logic [7:0]         pixel_out,
  output logic [COORD_W-1:0] x_pos,
  output logic [COORD_W-1:0] y_pos,
  output logic               valid_out,
  output logic               busy,
  output logic               frame_done
);

  // Reject geometries the counters and address bus cannot represent
  if (IMG_WIDTH < 2 || IMG_WIDTH > 1024 || IMG_HEIGHT < 2 || IMG_HEIGHT > 1024 ||
      HBLANK < 1 || HBLANK > 255 || ADDR_W < 1 || ADDR_W > 30 ||
      (1 << ADDR_W) < IMG_WIDTH * IMG_HEIGHT) begin : g_bad_params
    $error("frame_stream_source: illegal parameter combination");
  end

  src_state_t state, state_nxt;

  logic               cnt_clr;
  logic [COORD_W-1:0] x_cnt, y_cnt;
  logic               line_end, frame_end;

  logic               s1_valid, s1_last;
  logic [COORD_W-1:0] s1_x, s1_y;

  raster_counter #(
    .IMG_WIDTH (IMG_WIDTH),
    .IMG_HEIGHT(IMG_HEIGHT),
    .ADDR_W    (ADDR_W)
  ) u_raster_counter (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (cnt_clr),
    .en       (mem_rd_en),
    .x_cnt    (x_cnt),
    .y_cnt    (y_cnt),
    .addr     (mem_addr),
    .line_end (line_end),
    .frame_end(frame_end)
  );

`ifdef FRAME_SRC_HBLANK_EN
  localparam logic [7:0] BLANK_LAST = 8'(HBLANK - 1);
  logic [7:0] blank_cnt;

  // Count non-held cycles spent in line blanking; restart from zero on every entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blank_cnt <= '0;
    end else if (state != ST_HBLANK) begin
      blank_cnt <= '0;
    end else if (!hold) begin
      blank_cnt <= blank_cnt + 1'b1;
    end
  end
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state, read strobe and counter clear
  always_comb begin
    state_nxt = state;
    mem_rd_en = 1'b0;
    cnt_clr   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt = ST_ACTIVE;
          cnt_clr   = 1'b1;
        end
      end
      ST_ACTIVE: begin
        mem_rd_en = !hold;
        if (!hold) begin
          if (frame_end) begin
            state_nxt = ST_DRAIN;
          end
`ifdef FRAME_SRC_HBLANK_EN
          else if (line_end) begin
            state_nxt = ST_HBLANK;
          end
`endif
        end
      end
`ifdef FRAME_SRC_HBLANK_EN
      ST_HBLANK: begin
        if (!hold && blank_cnt == BLANK_LAST) begin
          state_nxt = ST_ACTIVE;
        end
      end
`endif
      ST_DRAIN: begin
        // frame_done is the registered last-pixel strobe, so leave as it is presented
        if (frame_done) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign busy = (state != ST_IDLE);

  // Stage 1: remember which reads were issued and for which coordinate
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_x     <= '0;
      s1_y     <= '0;
    end else begin
      s1_valid <= mem_rd_en;
      s1_last  <= mem_rd_en && frame_end;
      s1_x     <= x_cnt;
      s1_y     <= y_cnt;
    end
  end

  // Stage 2: capture returned data alongside its coordinate; outputs hold during bubbles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_out  <= 1'b0;
      frame_done <= 1'b0;
      pixel_out  <= '0;
      x_pos      <= '0;
      y_pos      <= '0;
    end else begin
      valid_out  <= s1_valid;
      frame_done <= s1_last;
      if (s1_valid) begin
        pixel_out <= mem_rd_data;
        x_pos     <= s1_x;
        y_pos     <= s1_y;
      end
    end
  end

endmodule

// File: doc/frame_stream_source.md
# frame_stream_source

- Raster-scan pixel source feeding the Sobel edge-detection stage.
- On `start`, reads one grayscale frame from a synchronous-read frame memory in row-major order.
- Emits each pixel with its (x, y) coordinate and a valid strobe, matching the Sobel stage's `pixel_in`/`x_pos`/`y_pos`/`valid_in` inputs.
- Sits between the frame memory (BRAM loaded by the image-load path) and the edge detector.

## Interface
Parameters:
- `IMG_WIDTH`, 960, pixels per line; legal range 2..1024.
- `IMG_HEIGHT`, 540, lines per frame; legal range 2..1024.
- `ADDR_W`, 20, memory address width; must satisfy 2^ADDR_W ≥ IMG_WIDTH*IMG_HEIGHT.
- `HBLANK`, 4, idle cycles inserted between lines; used only with `FRAME_SRC_HBLANK_EN`; legal range 1..255.

Ports:
- `clk`, in, 1, sole clock.
- `rst_n`, in, 1, asynchronous active-low reset.
- `start`, in, 1, begin frame; sampled only in IDLE.
- `hold`, in, 1, stall: freezes read issue, counters and blank counter.
- `mem_rd_en`, out, 1, read strobe.
- `mem_addr`, out, ADDR_W, read address.
- `mem_rd_data`, in, 8, read data, valid the cycle after `mem_rd_en`.
- `pixel_out`, out, 8, pixel to the Sobel stage.
- `x_pos`, out, 10, column of `pixel_out`.
- `y_pos`, out, 10, row of `pixel_out`.
- `valid_out`, out, 1, `pixel_out`/`x_pos`/`y_pos` valid.
- `busy`, out, 1, frame in progress.
- `frame_done`, out, 1, one-cycle pulse coincident with the last pixel's `valid_out`.

## Operation
State machine:
- IDLE: `start` → ACTIVE. Counters cleared on entry.
- ACTIVE:
  - `mem_rd_en = !hold`.
  - `mem_addr` = address counter; `x_cnt`/`y_cnt` track that address.
  - Each issued read: `x_cnt` increments.
  - At `x_cnt = IMG_WIDTH-1`: `x_cnt` wraps to 0 and `y_cnt` increments.
  - Address increments linearly from 0 to IMG_WIDTH*IMG_HEIGHT-1.
  - Line end (not last line), macro defined → HBLANK; otherwise stays in ACTIVE.
  - Last read issued (x = IMG_WIDTH-1, y = IMG_HEIGHT-1) → DRAIN.
- HBLANK: `mem_rd_en` = 0. Blank counter counts HBLANK non-held cycles, then → ACTIVE.
- DRAIN: wait for the in-flight last pixel. → IDLE in the cycle `frame_done` is high.

Output pipeline:
- Stage 1: registers `mem_rd_en`, `x_cnt`, `y_cnt`.
- Stage 2: registers `mem_rd_data` into `pixel_out` and stage-1 valid/coords into `valid_out`/`x_pos`/`y_pos`.
- With `hold`: no read issued → valid bubble. In-flight reads always complete; no skid buffer needed.

Other rules:
- `busy` = state ≠ IDLE.
- `start` while busy: ignored.
- Counters are unsigned, wrap exactly at the limits; no address exceeds IMG_WIDTH*IMG_HEIGHT-1.
- `pixel_out` holds its last value while `valid_out` = 0.

## Timing
Reset values:
- All outputs 0; state IDLE.
- Reset mid-frame aborts immediately. In-flight data is discarded; no `valid_out` or `frame_done` follows reset release.

Latency and throughput:
- `start` high at edge k → `busy` and first `mem_rd_en` (addr 0) in cycle k+1.
- `valid_out` for addr 0 (x=0, y=0) in cycle k+3.
- Read-to-valid latency is 2 cycles.
- One pixel per cycle when `hold` = 0.

Frame length:
- Macro off, no hold: `frame_done` at cycle k+2+W*H; `busy` falls at k+3+W*H.
- Macro on: add HBLANK*(H-1) cycles.

## Configuration
- `FRAME_SRC_HBLANK_EN` defined: HBLANK state compiled in; HBLANK idle cycles between consecutive lines, none after the last line.
- Undefined: no blank state or counter; lines are back-to-back and `HBLANK` is ignored.

## Structure
- Shared package `sobel_pkg`: IMG_WIDTH/IMG_HEIGHT defaults, coordinate width (10), state enum (IDLE, ACTIVE, HBLANK, DRAIN).
- One sub-module `raster_counter`: x/y/address counters with enable, clear, wrap and line-end/frame-end flags.

## Test plan
1. Reset, then idle 10 cycles → all outputs 0; `start` pulse with `rst_n` low → no activity.
2. W=4, H=3, macro off, `start` at edge 0 → addresses 0..11 in cycles 1..12; `valid_out` cycles 3..14 with (x,y) = (0,0),(1,0)…(3,2); `pixel_out` = memory contents; `frame_done` in cycle 14; `busy` low in cycle 15.
3. Same config, `hold` high cycles 5–7 → address 4 issued in cycle 8; exactly 3-cycle valid gap; no duplicated or skipped coordinate; `frame_done` in cycle 17.
4. Macro on, HBLANK=2, W=4, H=3 → 2-cycle `valid_out` gap after each x=3 of rows 0 and 1, none after row 2; `frame_done` in cycle 18.
5. `start` re-pulsed in cycle 6 and in the `frame_done` cycle → ignored; second `start` after IDLE restarts from address 0.
6. `rst_n` low in cycle 7 mid-frame → outputs 0 immediately; release, then `start` → scan restarts at (0,0) with no stale pixel.
